// File: rtl/jb_srx_wrssi_pkg.sv
// Shared types and widths for the wideband RSSI measurement engine.
package jb_srx_wrssi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_STORE
  } wrssi_state_t;

  localparam int WRSSI_PWR_W = 32;
  localparam int WRSSI_IQ_W  = 16;

  // Accumulator holds 2^max_len_log2 sums of at most 2^31 each, so it needs
  // max_len_log2 extra bits above the power width.
  function automatic int wrssi_acc_w(input int max_len_log2);
    return WRSSI_PWR_W + max_len_log2;
  endfunction

endpackage

// File: rtl/jb_iq_pwr.sv
// Two-stage registered instantaneous power I^2 + Q^2 for signed IQ samples.
// Stage 1 holds the squares, stage 2 holds their unsigned sum.
module jb_iq_pwr
  import jb_srx_wrssi_pkg::*;
#(
  parameter int DATA_W = WRSSI_IQ_W
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic                  vld_p0,
  input  logic [DATA_W-1:0]     i_p0,
  input  logic [DATA_W-1:0]     q_p0,
  output logic                  vld_p2,
  output logic [2*DATA_W-1:0]   pwr_p2
);

  logic signed [2*DATA_W-1:0] i_ext;
  logic signed [2*DATA_W-1:0] q_ext;
  logic signed [2*DATA_W-1:0] i_sq;
  logic signed [2*DATA_W-1:0] q_sq;
  logic        [2*DATA_W-1:0] i_sq_p1;
  logic        [2*DATA_W-1:0] q_sq_p1;
  logic                       vld_p1;

  // Sign-extend before squaring so the product is computed at full width.
  assign i_ext = $signed({{DATA_W{i_p0[DATA_W-1]}}, i_p0});
  assign q_ext = $signed({{DATA_W{q_p0[DATA_W-1]}}, q_p0});
  assign i_sq  = i_ext * i_ext;
  assign q_sq  = q_ext * q_ext;

  // Stage p0 -> p1: register the squares (each at most 2^30, always non-negative)
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      vld_p1  <= 1'b0;
      i_sq_p1 <= '0;
      q_sq_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      i_sq_p1 <= $unsigned(i_sq);
      q_sq_p1 <= $unsigned(q_sq);
    end
  end

  // Stage p1 -> p2: register the sum (at most 2^31, fits unsigned)
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      vld_p2 <= 1'b0;
      pwr_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      pwr_p2 <= i_sq_p1 + q_sq_p1;
    end
  end

endmodule

// File: rtl/jb_srx_wrssi.sv
// Wideband RSSI engine: integrates I^2+Q^2 of the observation stream over a
// power-of-two window per antenna, discarding a settling interval after each
// antenna switch or enable, and publishes the window mean per antenna.
module jb_srx_wrssi
  import jb_srx_wrssi_pkg::*;
#(
  parameter int N_ANTENNAS   = 4,
  parameter int MAX_LEN_LOG2 = 20
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [31:0] srx_tdata,
  input  logic        srx_tvalid,
  input  logic [2:0]  srx_wrssi_ant,
  input  logic        wrssi_enable,
  input  logic [4:0]  wrssi_len_log2,
  input  logic [15:0] wrssi_settle,
  output logic [31:0] wrssi_pwr [N_ANTENNAS],
  output logic [15:0] wrssi_upd_cnt [N_ANTENNAS],
  output logic        wrssi_upd,
  output logic [2:0]  wrssi_upd_ant,
  output logic        wrssi_busy
);

  localparam int         WRSSI_ACC_W = wrssi_acc_w(MAX_LEN_LOG2);
  localparam int         CNT_W       = MAX_LEN_LOG2 + 1;
  localparam logic [4:0] LEN_MAX     = 5'(MAX_LEN_LOG2);
  localparam logic [3:0] N_ANT       = 4'(N_ANTENNAS);

  // Saturate the requested window exponent to what the accumulator supports.
  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  wrssi_state_t state;
  wrssi_state_t state_nxt;

  logic [2:0]             cur_ant;
  logic [4:0]             len_q;
  logic [15:0]            settle_cnt;
  logic                   drain_cnt;
  logic [CNT_W-1:0]       smp_cnt;
  logic [CNT_W-1:0]       smp_cnt_inc;
  logic [CNT_W-1:0]       win_len;
  logic [WRSSI_ACC_W-1:0] acc;

  logic ant_ok;
  logic ant_chg;
  logic chg;
  logic take;
  logic go_settle;
  logic go_accum;
  logic clr_win;
  logic store;
  logic acc_en;

  logic                   vld_p2;
  logic [WRSSI_PWR_W-1:0] pwr_p2;

  assign ant_ok      = {1'b0, srx_wrssi_ant} < N_ANT;
  assign ant_chg     = srx_wrssi_ant != cur_ant;
  assign smp_cnt_inc = smp_cnt + CNT_W'(1);
  assign win_len     = {{(CNT_W-1){1'b0}}, 1'b1} << len_q;
  assign clr_win     = go_settle | go_accum;
  assign acc_en      = (state == ST_ACCUM) || (state == ST_DRAIN);
  assign wrssi_busy  = state != ST_IDLE;

  jb_iq_pwr #(
    .DATA_W (WRSSI_IQ_W)
  ) u_iq_pwr (
    .axis_aclk    (axis_aclk),
    .axis_aresetn (axis_aresetn),
    .vld_p0       (take),
    .i_p0         (srx_tdata[15:0]),
    .q_p0         (srx_tdata[31:16]),
    .vld_p2       (vld_p2),
    .pwr_p2       (pwr_p2)
  );

  // Measurement state register
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and window control; disable beats antenna change beats progress
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    go_settle = 1'b0;
    go_accum  = 1'b0;
    store     = 1'b0;
    chg       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wrssi_enable && ant_ok) begin
          go_settle = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!wrssi_enable) begin
          state_nxt = ST_IDLE;
        end else if (ant_chg) begin
          chg = 1'b1;
        end else if (settle_cnt <= 16'd1) begin
          go_accum = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (!wrssi_enable) begin
          state_nxt = ST_IDLE;
        end else if (ant_chg) begin
          chg = 1'b1;
        end else if (srx_tvalid) begin
          take = 1'b1;
          if (smp_cnt_inc == win_len) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!wrssi_enable) begin
          state_nxt = ST_IDLE;
        end else if (ant_chg) begin
          chg = 1'b1;
        end else if (drain_cnt) begin
          state_nxt = ST_STORE;
        end
      end
      ST_STORE: begin
        // The result of the finished window is always written, even when
        // the cycle also sees a disable or an antenna switch.
        store = 1'b1;
        if (!wrssi_enable) begin
          state_nxt = ST_IDLE;
        end else if (ant_chg) begin
          chg = 1'b1;
        end else begin
          go_accum = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (chg) begin
      if (ant_ok) begin
        go_settle = 1'b1;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
    if (go_settle) begin
      state_nxt = ST_SETTLE;
    end
    if (go_accum) begin
      state_nxt = ST_ACCUM;
    end
  end

  // Window bookkeeping: antenna latch, settle countdown, length, sample count
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      cur_ant    <= '0;
      len_q      <= '0;
      settle_cnt <= '0;
      drain_cnt  <= 1'b0;
      smp_cnt    <= '0;
    end else begin
      if (go_settle) begin
        cur_ant    <= srx_wrssi_ant;
        settle_cnt <= wrssi_settle;
      end else if ((state == ST_SETTLE) && (settle_cnt != 16'd0)) begin
        settle_cnt <= settle_cnt - 16'd1;
      end
      if (go_accum) begin
        len_q <= clamp_len(wrssi_len_log2);
      end
      drain_cnt <= (state == ST_DRAIN);
      if (clr_win) begin
        smp_cnt <= '0;
      end else if (take) begin
        smp_cnt <= smp_cnt_inc;
      end
    end
  end

  // Accumulator: only sums arriving during ACCUM/DRAIN belong to the window,
  // so leftovers of an aborted window never leak into the next one.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      acc <= '0;
    end else if (clr_win) begin
      acc <= '0;
    end else if (vld_p2 && acc_en) begin
      acc <= acc + {{(WRSSI_ACC_W-WRSSI_PWR_W){1'b0}}, pwr_p2};
    end
  end

  // Per-antenna result registers and update strobe
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      for (int a = 0; a < N_ANTENNAS; a++) begin
        wrssi_pwr[a]     <= '0;
        wrssi_upd_cnt[a] <= '0;
      end
      wrssi_upd     <= 1'b0;
      wrssi_upd_ant <= '0;
    end else begin
      wrssi_upd <= store;
      if (store) begin
        wrssi_upd_ant <= cur_ant;
        for (int a = 0; a < N_ANTENNAS; a++) begin
          if (cur_ant == 3'(a)) begin
            wrssi_pwr[a]     <= WRSSI_PWR_W'(acc >> len_q);
            wrssi_upd_cnt[a] <= wrssi_upd_cnt[a] + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jb_srx_wrssi.sv
// Self-checking bench for jb_srx_wrssi: directed cases plus randomized
// traffic against a timeline model of the measurement windows.
module tb_jb_srx_wrssi;

  localparam int NA   = 4;
  localparam int MAXL = 20;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] tdata;
  logic        tvalid;
  logic [2:0]  ant;
  logic        en;
  logic [4:0]  len;
  logic [15:0] settle;
  logic [31:0] pwr [NA];
  logic [15:0] ucnt [NA];
  logic        upd;
  logic [2:0]  upd_ant;
  logic        busy;

  always #5 clk = ~clk;

  jb_srx_wrssi #(
    .N_ANTENNAS   (NA),
    .MAX_LEN_LOG2 (MAXL)
  ) dut (
    .axis_aclk      (clk),
    .axis_aresetn   (rstn),
    .srx_tdata      (tdata),
    .srx_tvalid     (tvalid),
    .srx_wrssi_ant  (ant),
    .wrssi_enable   (en),
    .wrssi_len_log2 (len),
    .wrssi_settle   (settle),
    .wrssi_pwr      (pwr),
    .wrssi_upd_cnt  (ucnt),
    .wrssi_upd      (upd),
    .wrssi_upd_ant  (upd_ant),
    .wrssi_busy     (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the measurement as a timeline: a settle countdown of max(settle,1)
  // edges, a window of 2^len valid samples, then three edges until the
  // result lands (two drain edges plus the store edge).
  bit              m_act;
  bit              m_inwin;
  int              m_cur;
  int              m_skip;
  int              m_len;
  int              m_cnt;
  int              m_cd;
  longint unsigned m_sum;
  longint unsigned e_pwr [NA];
  int              e_cnt [NA];
  bit              e_upd;
  int              e_ant;

  function automatic longint unsigned iq_pow(input logic [31:0] d);
    int iv;
    int qv;
    iv = int'($signed(d[15:0]));
    qv = int'($signed(d[31:16]));
    return longint'(iv * iv) + longint'(qv * qv);
  endfunction

  task automatic m_reset();
    m_act = 0; m_inwin = 0; m_cur = 0; m_skip = 0; m_len = 0;
    m_cnt = 0; m_cd = 0; m_sum = 0; e_upd = 0; e_ant = 0;
    for (int a = 0; a < NA; a++) begin
      e_pwr[a] = 0;
      e_cnt[a] = 0;
    end
  endtask

  task automatic m_restart(input int a);
    m_act   = 1;
    m_cur   = a;
    m_skip  = (settle == 0) ? 1 : int'(settle);
    m_inwin = 0;
    m_cd    = 0;
  endtask

  task automatic m_start();
    m_len   = (int'(len) > MAXL) ? MAXL : int'(len);
    m_sum   = 0;
    m_cnt   = 0;
    m_inwin = 1;
  endtask

  task automatic m_edge();
    e_upd = 0;
    if (!m_act) begin
      if (en && int'(ant) < NA) m_restart(int'(ant));
      return;
    end
    if (m_cd == 1) begin
      e_pwr[m_cur] = (m_sum >> m_len) & 64'hFFFF_FFFF;
      e_cnt[m_cur] = (e_cnt[m_cur] + 1) % 65536;
      e_upd = 1;
      e_ant = m_cur;
    end
    if (!en) begin
      m_act = 0; m_cd = 0; m_inwin = 0;
      return;
    end
    if (int'(ant) != m_cur) begin
      if (int'(ant) < NA) m_restart(int'(ant));
      else begin
        m_act = 0; m_cd = 0; m_inwin = 0;
      end
      return;
    end
    if (m_cd == 1) begin
      m_cd = 0;
      m_start();
    end else if (m_cd > 1) begin
      m_cd--;
    end else if (!m_inwin) begin
      m_skip--;
      if (m_skip == 0) m_start();
    end else if (tvalid) begin
      m_sum += iq_pow(tdata);
      m_cnt++;
      if (m_cnt == (1 << m_len)) m_cd = 3;
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rstn) m_reset();
    else m_edge();
    @(negedge clk);
    chk("upd", upd, e_upd);
    chk("busy", busy, m_act);
    if (e_upd) begin
      chk("upd_ant", upd_ant, e_ant);
      for (int a = 0; a < NA; a++) begin
        chk($sformatf("pwr%0d", a), pwr[a], e_pwr[a]);
        chk($sformatf("ucnt%0d", a), ucnt[a], e_cnt[a]);
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en   = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  int n;
  int last;
  int nupd;
  int duty;

  initial begin
    m_reset();
    rstn = 1'b0; en = 1'b0; ant = '0; tvalid = 1'b0; tdata = '0;
    len = '0; settle = '0;
    repeat (3) step();
    rstn = 1'b1;
    for (int a = 0; a < NA; a++) begin
      chk($sformatf("rst_pwr%0d", a), pwr[a], 0);
      chk($sformatf("rst_ucnt%0d", a), ucnt[a], 0);
    end
    chk("rst_upd_ant", upd_ant, 0);
    chk("rst_upd", upd, 0);

    // Constant I=1000, Q=0: latency and mean power
    ant = 3'd1; len = 5'd4; settle = 16'd10; tvalid = 1'b1;
    tdata = {16'd0, 16'd1000};
    en = 1'b1;
    for (n = 1; n <= 100; n++) begin
      step();
      if (upd) break;
    end
    chk("lat_first_upd", n, 30);
    chk("pwr_1000", pwr[1], 1000000);
    chk("upd_ant_1", upd_ant, 1);
    en = 1'b0;
    repeat (3) step();

    // Full-scale negative IQ, single-sample windows back to back
    do_reset();
    ant = 3'd0; len = 5'd0; settle = 16'd0; tvalid = 1'b1;
    tdata = {16'h8000, 16'h8000};
    en = 1'b1;
    last = -1; nupd = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (upd) begin
        if (last >= 0) chk("upd_period", c - last, 4);
        last = c;
        nupd++;
      end
    end
    chk("pwr_fullscale", pwr[0], 32'h8000_0000);
    chk("n_upd_fullscale", nupd, 9);
    chk("ucnt_fullscale", ucnt[0], 9);
    en = 1'b0;
    step();

    // 50% tvalid duty with junk on invalid cycles
    do_reset();
    ant = 3'd3; len = 5'd3; settle = 16'd4;
    en = 1'b1;
    for (n = 1; n <= 100; n++) begin
      tvalid = n[0];
      tdata  = tvalid ? {16'd4, 16'd3} : $urandom;
      step();
      if (upd) break;
    end
    chk("pwr_duty", pwr[3], 25);
    chk("upd_ant_duty", upd_ant, 3);
    en = 1'b0;
    step();

    // Antenna 0 -> 2 after 5 of 16 samples
    do_reset();
    ant = 3'd0; len = 5'd4; settle = 16'd2; tvalid = 1'b1;
    tdata = {16'd20, 16'd10};
    en = 1'b1;
    repeat (8) step();
    ant = 3'd2;
    for (n = 1; n <= 100; n++) begin
      step();
      if (upd) break;
    end
    chk("lat_after_switch", n, 22);
    chk("upd_ant_switch", upd_ant, 2);
    chk("pwr_ant2", pwr[2], 500);
    chk("ucnt_ant0_kept", ucnt[0], 0);
    chk("ucnt_ant2", ucnt[2], 1);

    // Drop enable mid-window, then reset mid-window
    nupd = 0;
    repeat (6) begin step(); if (upd) nupd++; end
    en = 1'b0;
    repeat (3) begin step(); if (upd) nupd++; end
    chk("busy_after_disable", busy, 0);
    en = 1'b1;
    repeat (10) begin step(); if (upd) nupd++; end
    chk("no_upd_partial", nupd, 0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("busy_after_reset", busy, 0);
    for (int a = 0; a < NA; a++) begin
      chk($sformatf("rst_mid_pwr%0d", a), pwr[a], 0);
      chk($sformatf("rst_mid_ucnt%0d", a), ucnt[a], 0);
    end

    // Out-of-range antenna stays idle
    en = 1'b0;
    do_reset();
    ant = 3'd5; en = 1'b1;
    repeat (10) step();
    chk("busy_bad_ant", busy, 0);

    // Oversized window exponent is clamped: no result within a short run
    do_reset();
    ant = 3'd1; len = 5'd31; settle = 16'd1; tvalid = 1'b1;
    en = 1'b1;
    nupd = 0;
    repeat (3000) begin
      tdata = $urandom;
      step();
      if (upd) nupd++;
    end
    chk("clamp_no_upd", nupd, 0);
    chk("clamp_busy", busy, 1);
    en = 1'b0;
    step();

    // Randomized traffic with antenna switches, enable gaps and resets
    do_reset();
    for (int r = 0; r < 40; r++) begin
      len    = 5'($urandom_range(0, 4));
      settle = 16'($urandom_range(0, 12));
      ant    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      duty   = $urandom_range(30, 100);
      for (int c = 0; c < 200; c++) begin
        en     = ($urandom_range(0, 199) != 0);
        tvalid = ($urandom_range(1, 100) <= duty);
        tdata  = $urandom;
        if ($urandom_range(0, 119) == 0) ant = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 99) == 0) len = 5'($urandom_range(0, 4));
        if ($urandom_range(0, 149) == 0) settle = 16'($urandom_range(0, 12));
        rstn = ($urandom_range(0, 599) != 0);
        step();
      end
      rstn = 1'b1;
      en = 1'b0;
      step();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jb_srx_wrssi.md
# jb_srx_wrssi

Wideband RSSI (WRSSI) measurement engine downstream of the SRX control block. Consumes the same observation IQ stream that feeds DPD, together with the registered `srx_wrssi_ant` antenna index, and integrates instantaneous power I²+Q² over a programmable power-of-two window. After each antenna switch it discards a programmable settling interval. Each completed window is written into a per-antenna power register readable by the control/regmap layer.

## Interface
Parameters:
- `N_ANTENNAS`, 4, number of per-antenna result registers; antenna indices ≥ N_ANTENNAS are never measured
- `MAX_LEN_LOG2`, 20, upper clamp on the window exponent; accumulator width is 32+MAX_LEN_LOG2

Ports:
- `axis_aclk`  in  1  sole clock, all logic on rising edge
- `axis_aresetn`  in  1  synchronous, active-low reset
- `srx_tdata`  in  32  observation sample; Q = [31:16], I = [15:0], both signed two's complement
- `srx_tvalid`  in  1  sample qualifier; gaps allowed
- `srx_wrssi_ant`  in  3  antenna currently routed to the observation path
- `wrssi_enable`  in  1  measurement enable (level)
- `wrssi_len_log2`  in  5  window = 2^len samples; values > MAX_LEN_LOG2 are clamped
- `wrssi_settle`  in  16  clock cycles discarded after an antenna change or enable
- `wrssi_pwr[N_ANTENNAS]`  out  32 each  mean power of the last completed window per antenna
- `wrssi_upd_cnt[N_ANTENNAS]`  out  16 each  per-antenna completed-window count, wraps at 0xFFFF→0
- `wrssi_upd`  out  1  one-cycle pulse on each result write
- `wrssi_upd_ant`  out  3  antenna written, valid with `wrssi_upd`
- `wrssi_busy`  out  1  high in any state except IDLE

## Operation
- States: IDLE, SETTLE, ACCUM, DRAIN, STORE.
- IDLE → SETTLE when `wrssi_enable`=1 and `srx_wrssi_ant` < N_ANTENNAS. Latch the antenna into `cur_ant`, load the settle counter, and clear the accumulator and sample counter.
- SETTLE: count cycles regardless of tvalid. After `wrssi_settle` cycles → ACCUM. A value of 0 spends exactly one cycle in SETTLE.
- ACCUM: each cycle with `srx_tvalid`=1 enters the square pipeline and increments the sample counter. When the counter reaches 2^len → DRAIN. Samples after the last one are ignored.
- DRAIN: fixed 2 cycles while the pipeline empties into the accumulator, then → STORE.
- STORE (1 cycle):
  - `wrssi_pwr[cur_ant]` ← acc >> len, truncated to 32 bits.
  - `wrssi_upd_cnt[cur_ant]`++.
  - Pulse `wrssi_upd`.
  - Clear the accumulator and counter, then → ACCUM. Continuous back-to-back windows run with no re-settle.
- Antenna change: `srx_wrssi_ant` ≠ `cur_ant` in SETTLE, ACCUM or DRAIN aborts the window. Nothing is stored. Relatch, clear, → SETTLE.
  - In STORE, the store completes for the old `cur_ant`, then → SETTLE with the new antenna.
  - A new antenna ≥ N_ANTENNAS → IDLE.
- `wrssi_enable`=0 in any state → IDLE next cycle. A partial window is discarded; STORE in progress still completes.
- Arithmetic:
  - I², Q² are 32-bit unsigned; their sum is 32-bit unsigned (max 2^31 at I=Q=−32768).
  - Accumulator is 32+MAX_LEN_LOG2 bits and cannot overflow.
  - `len` is sampled at window start (ACCUM entry) and held for the window.

## Timing
- Reset values:
  - State IDLE.
  - `wrssi_pwr` all 0, `wrssi_upd_cnt` all 0.
  - `wrssi_upd` 0, `wrssi_upd_ant` 0, `wrssi_busy` 0.
  - Accumulator, counters and pipeline cleared.
- Reset applied mid-window behaves identically to power-up: results are cleared, not held.
- Square pipeline:
  - Stage 1 registers I², Q².
  - Stage 2 registers the sum and adds it into the accumulator.
  - Latency from sample to accumulator is 2 cycles.
- Last accepted sample at cycle t: DRAIN at t+1, t+2; STORE at t+3; `wrssi_pwr`/`wrssi_upd` visible at t+4.
- Enable-to-first-result, continuous tvalid: 1 (IDLE→SETTLE) + max(settle,1) + 2^len + 3 cycles.
- No backpressure; the block never drives tready.

## Structure
- Shared package `jb_srx_wrssi_pkg`:
  - State enum.
  - `WRSSI_PWR_W`=32.
  - `WRSSI_ACC_W` function of MAX_LEN_LOG2.
- Sub-module `jb_iq_pwr`: 2-stage registered I²+Q², reusable by other power monitors.
- Result registers: N_ANTENNAS-entry array indexed by `cur_ant`.

## Test plan
- I=1000, Q=0 constant, len=4, settle=10, ant=1 → `wrssi_pwr[1]`=1 000 000, `wrssi_upd_ant`=1; first `wrssi_upd` 1+10+16+3 cycles after enable.
- I=Q=−32768, len=0 → `wrssi_pwr`=0x8000_0000, no overflow; repeated upd every 4 cycles, `upd_cnt` increments.
- tvalid 50% duty, I=3, Q=4, len=3 → `pwr`=25 after exactly 8 valid samples; invalid cycles contribute nothing.
- Antenna 0→2 after 5 of 16 samples → no write to ant 0, re-settle, next write lands in `wrssi_pwr[2]`; `upd_cnt[0]` unchanged.
- Drop enable mid-window, then drop reset mid-window → no upd pulse; reset clears all `pwr`/`upd_cnt` to 0 and `busy`=0 next cycle.
- ant=5 with N_ANTENNAS=4 → remains IDLE, `busy`=0; `len`=31 → clamped to 20 (2^20-sample window).
